// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared owner encoding and memory command type for the data-memory arbiter
package dmem_arbiter_pkg;

    // Widest address/data the command struct carries; narrower XLEN uses the low bits.
    localparam int DMEM_XLEN_MAX = 64;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    typedef struct packed {
        logic [DMEM_XLEN_MAX-1:0] addr;
        logic [DMEM_XLEN_MAX-1:0] wr_data;
        logic [3:0]               size;
        logic                     read;
        logic                     write;
    } mem_cmd_t;

    function automatic owner_e other_master(input owner_e o);
        return (o == OWN_CORE) ? OWN_EXT : OWN_CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_policy.sv
// rtl/dmem_arbiter_arb_policy.sv - next-owner selection with anti-starvation counter and round-robin pointer
module dmem_arbiter_arb_policy
    import dmem_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_core_req,
    input  logic   i_ext_req,
    output owner_e o_next_owner
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;
    // rr_ptr names the master that wins the next contended cycle; never IDLE.
    owner_e     rr_ptr;
    owner_e     rr_ptr_d;
    owner_e     next_owner;

    always_comb begin
        next_owner = OWN_IDLE;
        if (i_core_req && i_ext_req) begin
            if (ARB_MODE == 0) begin
                next_owner = (wait_cnt == MAX_WAIT_C) ? OWN_EXT : OWN_CORE;
            end else begin
                next_owner = rr_ptr;
            end
        end else if (i_core_req) begin
            next_owner = OWN_CORE;
        end else if (i_ext_req) begin
            next_owner = OWN_EXT;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt;
        if ((ARB_MODE != 0) || !i_ext_req || (next_owner == OWN_EXT)) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt + 8'd1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr;
        if (next_owner != OWN_IDLE) begin
            rr_ptr_d = other_master(next_owner);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= 8'd0;
            rr_ptr   <= OWN_CORE;
        end else begin
            wait_cnt <= wait_cnt_d;
            rr_ptr   <= rr_ptr_d;
        end
    end

    assign o_next_owner = next_owner;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between the core and an external master
// Request in N, command in N+1, read data in N+2; XLEN up to DMEM_XLEN_MAX.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_core_req,
    output logic            o_core_gnt,
    output logic            o_core_stall,
    input  logic [XLEN-1:0] i_core_addr,
    input  logic [XLEN-1:0] i_core_wr_data,
    input  logic [3:0]      i_core_size,
    input  logic            i_core_read,
    input  logic            i_core_write,
    output logic [XLEN-1:0] o_core_rd_data,
    input  logic            i_ext_req,
    output logic            o_ext_gnt,
    input  logic [XLEN-1:0] i_ext_addr,
    input  logic [XLEN-1:0] i_ext_wr_data,
    input  logic [3:0]      i_ext_size,
    input  logic            i_ext_read,
    input  logic            i_ext_write,
    output logic [XLEN-1:0] o_ext_rd_data,
    output logic            o_ext_rvalid,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wr_data,
    output logic [3:0]      o_mem_size,
    output logic            o_mem_read,
    output logic            o_mem_write,
    input  logic [XLEN-1:0] i_mem_rd_data
);

    owner_e   owner;
    owner_e   next_owner;
    owner_e   rd_owner;
    logic     core_stall_q;
    mem_cmd_t core_cmd;
    mem_cmd_t ext_cmd;
    mem_cmd_t mem_cmd;

    dmem_arbiter_arb_policy #(
        .ARB_MODE (ARB_MODE),
        .MAX_WAIT (MAX_WAIT)
    ) u_arb_policy (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_core_req   (i_core_req),
        .i_ext_req    (i_ext_req),
        .o_next_owner (next_owner)
    );

    always_comb begin
        core_cmd                    = '0;
        core_cmd.addr[XLEN-1:0]     = i_core_addr;
        core_cmd.wr_data[XLEN-1:0]  = i_core_wr_data;
        core_cmd.size               = i_core_size;
        core_cmd.read               = i_core_read;
        core_cmd.write              = i_core_write;
        ext_cmd                     = '0;
        ext_cmd.addr[XLEN-1:0]      = i_ext_addr;
        ext_cmd.wr_data[XLEN-1:0]   = i_ext_wr_data;
        ext_cmd.size                = i_ext_size;
        ext_cmd.read                = i_ext_read;
        ext_cmd.write               = i_ext_write;
    end

    // A granted master with no strobe still owns the slot; the command is simply empty.
    always_comb begin
        mem_cmd = '0;
        case (owner)
            OWN_CORE: mem_cmd = core_cmd;
            OWN_EXT:  mem_cmd = ext_cmd;
            default:  mem_cmd = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner        <= OWN_IDLE;
            rd_owner     <= OWN_IDLE;
            core_stall_q <= 1'b0;
        end else begin
            owner        <= next_owner;
            rd_owner     <= mem_cmd.read ? owner : OWN_IDLE;
            core_stall_q <= i_core_req && (next_owner != OWN_CORE);
        end
    end

    generate
        if (XLEN < DMEM_XLEN_MAX) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{mem_cmd.addr[DMEM_XLEN_MAX-1:XLEN],
                                  mem_cmd.wr_data[DMEM_XLEN_MAX-1:XLEN]};
        end
    endgenerate

    assign o_core_gnt     = (owner == OWN_CORE);
    assign o_ext_gnt      = (owner == OWN_EXT);
    assign o_core_stall   = core_stall_q;
    assign o_mem_addr     = mem_cmd.addr[XLEN-1:0];
    assign o_mem_wr_data  = mem_cmd.wr_data[XLEN-1:0];
    assign o_mem_size     = mem_cmd.size;
    assign o_mem_read     = mem_cmd.read;
    assign o_mem_write    = mem_cmd.write;
    // The core's write-back stage samples read data without a valid.
    assign o_core_rd_data = i_mem_rd_data;
    assign o_ext_rd_data  = i_mem_rd_data;
    assign o_ext_rvalid   = (rd_owner == OWN_EXT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter in fixed-priority and round-robin modes
module tb_dmem_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 8;
    localparam int VW       = 6 + 4 + 4 * XLEN;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_core_req, i_core_read, i_core_write;
    logic            i_ext_req, i_ext_read, i_ext_write;
    logic [XLEN-1:0] i_core_addr, i_core_wr_data, i_ext_addr, i_ext_wr_data, i_mem_rd_data;
    logic [3:0]      i_core_size, i_ext_size;

    logic            fp_core_gnt, fp_core_stall, fp_ext_gnt, fp_ext_rvalid, fp_mem_read, fp_mem_write;
    logic [3:0]      fp_mem_size;
    logic [XLEN-1:0] fp_core_rd_data, fp_ext_rd_data, fp_mem_addr, fp_mem_wr_data;
    logic            rr_core_gnt, rr_core_stall, rr_ext_gnt, rr_ext_rvalid, rr_mem_read, rr_mem_write;
    logic [3:0]      rr_mem_size;
    logic [XLEN-1:0] rr_core_rd_data, rr_ext_rd_data, rr_mem_addr, rr_mem_wr_data;

    logic [VW-1:0]   obs_fp, obs_rr;

    int errors = 0;
    int checks = 0;

    // Reference model state: owners 0=idle 1=core 2=ext.
    int own_fp, own_rr, losses, last_rr;
    bit stall_fp, stall_rr, rv_fp, rv_rr;

    assign obs_fp = {fp_core_gnt, fp_ext_gnt, fp_core_stall, fp_ext_rvalid, fp_mem_read, fp_mem_write,
                     fp_mem_size, fp_mem_addr, fp_mem_wr_data, fp_core_rd_data, fp_ext_rd_data};
    assign obs_rr = {rr_core_gnt, rr_ext_gnt, rr_core_stall, rr_ext_rvalid, rr_mem_read, rr_mem_write,
                     rr_mem_size, rr_mem_addr, rr_mem_wr_data, rr_core_rd_data, rr_ext_rd_data};

    dmem_arbiter #(.XLEN(XLEN), .ARB_MODE(0), .MAX_WAIT(MAX_WAIT)) dut_fp (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_core_req(i_core_req), .o_core_gnt(fp_core_gnt), .o_core_stall(fp_core_stall),
        .i_core_addr(i_core_addr), .i_core_wr_data(i_core_wr_data), .i_core_size(i_core_size),
        .i_core_read(i_core_read), .i_core_write(i_core_write), .o_core_rd_data(fp_core_rd_data),
        .i_ext_req(i_ext_req), .o_ext_gnt(fp_ext_gnt), .i_ext_addr(i_ext_addr),
        .i_ext_wr_data(i_ext_wr_data), .i_ext_size(i_ext_size), .i_ext_read(i_ext_read),
        .i_ext_write(i_ext_write), .o_ext_rd_data(fp_ext_rd_data), .o_ext_rvalid(fp_ext_rvalid),
        .o_mem_addr(fp_mem_addr), .o_mem_wr_data(fp_mem_wr_data), .o_mem_size(fp_mem_size),
        .o_mem_read(fp_mem_read), .o_mem_write(fp_mem_write), .i_mem_rd_data(i_mem_rd_data)
    );

    dmem_arbiter #(.XLEN(XLEN), .ARB_MODE(1), .MAX_WAIT(MAX_WAIT)) dut_rr (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_core_req(i_core_req), .o_core_gnt(rr_core_gnt), .o_core_stall(rr_core_stall),
        .i_core_addr(i_core_addr), .i_core_wr_data(i_core_wr_data), .i_core_size(i_core_size),
        .i_core_read(i_core_read), .i_core_write(i_core_write), .o_core_rd_data(rr_core_rd_data),
        .i_ext_req(i_ext_req), .o_ext_gnt(rr_ext_gnt), .i_ext_addr(i_ext_addr),
        .i_ext_wr_data(i_ext_wr_data), .i_ext_size(i_ext_size), .i_ext_read(i_ext_read),
        .i_ext_write(i_ext_write), .o_ext_rd_data(rr_ext_rd_data), .o_ext_rvalid(rr_ext_rvalid),
        .o_mem_addr(rr_mem_addr), .o_mem_wr_data(rr_mem_wr_data), .o_mem_size(rr_mem_size),
        .o_mem_read(rr_mem_read), .o_mem_write(rr_mem_write), .i_mem_rd_data(i_mem_rd_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void model_reset();
        own_fp = 0; own_rr = 0; losses = 0; last_rr = 0;
        stall_fp = 0; stall_rr = 0; rv_fp = 0; rv_rr = 0;
    endfunction

    // Clock-edge update of the reference model from the requests present at that edge.
    function automatic void model_edge();
        int w_fp, w_rr;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        rv_fp = (own_fp == 2) && i_ext_read;
        rv_rr = (own_rr == 2) && i_ext_read;
        if (i_core_req && !(i_ext_req && losses == MAX_WAIT)) w_fp = 1;
        else if (i_ext_req) w_fp = 2;
        else w_fp = 0;
        if (i_core_req && i_ext_req) w_rr = (last_rr == 1) ? 2 : 1;
        else if (i_core_req) w_rr = 1;
        else if (i_ext_req) w_rr = 2;
        else w_rr = 0;
        stall_fp = i_core_req && (w_fp != 1);
        stall_rr = i_core_req && (w_rr != 1);
        if (i_ext_req && w_fp != 2) losses = (losses < MAX_WAIT) ? losses + 1 : losses;
        else losses = 0;
        if (w_rr != 0) last_rr = w_rr;
        own_fp = w_fp;
        own_rr = w_rr;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int own, input bit stall, input bit rv);
        logic r, w;
        logic [3:0] s;
        logic [XLEN-1:0] a, d;
        r = 1'b0; w = 1'b0; s = '0; a = '0; d = '0;
        if (own == 1) begin
            r = i_core_read; w = i_core_write; s = i_core_size; a = i_core_addr; d = i_core_wr_data;
        end else if (own == 2) begin
            r = i_ext_read; w = i_ext_write; s = i_ext_size; a = i_ext_addr; d = i_ext_wr_data;
        end
        return {own == 1, own == 2, stall, rv, r, w, s, a, d, i_mem_rd_data, i_mem_rd_data};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    task automatic drive_idle();
        i_core_req = 0; i_core_read = 0; i_core_write = 0; i_core_size = '0;
        i_core_addr = '0; i_core_wr_data = '0;
        i_ext_req = 0; i_ext_read = 0; i_ext_write = 0; i_ext_size = '0;
        i_ext_addr = '0; i_ext_wr_data = '0;
        i_mem_rd_data = $urandom;
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        model_reset();
        drive_idle();
        tick();
        i_core_req = 1; i_ext_req = 1; i_core_read = 1; i_ext_read = 1;
        #1;
        checks++;
        if ({fp_core_gnt, fp_ext_gnt, fp_core_stall, fp_ext_rvalid, fp_mem_read, fp_mem_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_fp_ctrl: got %b expected 000000",
                     {fp_core_gnt, fp_ext_gnt, fp_core_stall, fp_ext_rvalid, fp_mem_read, fp_mem_write});
        end
        tick();
        #1;
        checks++;
        if (obs_rr !== exp_vec(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_rr_vec: got %h expected %h", obs_rr, exp_vec(0, 0, 0));
        end
        drive_idle();
        i_rst_n = 1;
        #1;
        tick();
    endtask

    task automatic test_core_only();
        drive_idle();
        i_core_req = 1;
        #1;
        tick();
        i_core_req = 0; i_core_read = 1; i_core_addr = 32'h100; i_core_size = 4'hF;
        #1;
        checks++;
        if ({fp_core_gnt, fp_ext_gnt, fp_mem_read, fp_mem_write, fp_mem_addr} !== {4'b1010, 32'h100}) begin
            errors++;
            $display("FAIL core_cmd: got %h expected %h",
                     {fp_core_gnt, fp_ext_gnt, fp_mem_read, fp_mem_write, fp_mem_addr}, {4'b1010, 32'h100});
        end
        checks++;
        if (obs_rr !== exp_vec(own_rr, stall_rr, rv_rr)) begin
            errors++;
            $display("FAIL core_cmd_rr: got %h expected %h", obs_rr, exp_vec(own_rr, stall_rr, rv_rr));
        end
        tick();
        i_core_read = 0; i_core_addr = '0; i_mem_rd_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({fp_core_rd_data, fp_ext_rvalid, fp_core_gnt, fp_mem_read} !== {32'hDEADBEEF, 3'b000}) begin
            errors++;
            $display("FAIL core_rdata: got %h expected %h",
                     {fp_core_rd_data, fp_ext_rvalid, fp_core_gnt, fp_mem_read}, {32'hDEADBEEF, 3'b000});
        end
        tick();
    endtask

    task automatic test_ext_only();
        logic [XLEN-1:0] rd;
        drive_idle();
        i_ext_req = 1;
        #1;
        tick();
        i_ext_write = 1; i_ext_addr = 32'h200; i_ext_wr_data = 32'h55AA; i_ext_size = 4'b0011;
        #1;
        checks++;
        if ({fp_ext_gnt, fp_core_gnt, fp_mem_write, fp_mem_read, fp_ext_rvalid, fp_mem_size, fp_mem_addr,
             fp_mem_wr_data} !== {5'b10100, 4'b0011, 32'h200, 32'h55AA}) begin
            errors++;
            $display("FAIL ext_write: got %h expected %h",
                     {fp_ext_gnt, fp_core_gnt, fp_mem_write, fp_mem_read, fp_ext_rvalid, fp_mem_size,
                      fp_mem_addr, fp_mem_wr_data}, {5'b10100, 4'b0011, 32'h200, 32'h55AA});
        end
        tick();
        i_ext_req = 0; i_ext_write = 0; i_ext_read = 1; i_ext_addr = 32'h204; i_ext_size = 4'hF;
        #1;
        checks++;
        if ({rr_ext_gnt, rr_mem_read, rr_mem_write, rr_ext_rvalid} !== 4'b1100) begin
            errors++;
            $display("FAIL ext_read_cmd: got %b expected 1100",
                     {rr_ext_gnt, rr_mem_read, rr_mem_write, rr_ext_rvalid});
        end
        tick();
        i_ext_read = 0;
        rd = $urandom;
        i_mem_rd_data = rd;
        #1;
        checks++;
        if ({fp_ext_rvalid, fp_ext_rd_data, fp_ext_gnt} !== {1'b1, rd, 1'b0}) begin
            errors++;
            $display("FAIL ext_rvalid: got %h expected %h", {fp_ext_rvalid, fp_ext_rd_data, fp_ext_gnt},
                     {1'b1, rd, 1'b0});
        end
        tick();
        #1;
        checks++;
        if (fp_ext_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ext_rvalid_single: got %b expected 0", fp_ext_rvalid);
        end
    endtask

    task automatic test_contention_fixed();
        bit exp_ext;
        drive_idle();
        #1;
        tick();
        i_core_req = 1; i_ext_req = 1; i_core_read = 1; i_ext_read = 1;
        i_core_addr = 32'h300; i_ext_addr = 32'h400;
        for (int k = 0; k < 27; k++) begin
            tick();
            i_mem_rd_data = $urandom;
            #1;
            exp_ext = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            checks++;
            if ({fp_ext_gnt, fp_core_gnt, fp_core_stall} !== {exp_ext, !exp_ext, exp_ext}) begin
                errors++;
                $display("FAIL fp_contend k=%0d: got gnt_ext/gnt_core/stall=%b expected %b", k,
                         {fp_ext_gnt, fp_core_gnt, fp_core_stall}, {exp_ext, !exp_ext, exp_ext});
            end
            checks++;
            if (obs_fp !== exp_vec(own_fp, stall_fp, rv_fp)) begin
                errors++;
                $display("FAIL fp_contend_vec k=%0d: got %h expected %h", k, obs_fp,
                         exp_vec(own_fp, stall_fp, rv_fp));
            end
        end
        drive_idle();
        #1;
        tick();
    endtask

    task automatic test_contention_rr();
        bit prev_ext;
        drive_idle();
        #1;
        tick();
        tick();
        prev_ext = 0;
        i_core_req = 1; i_ext_req = 1; i_core_read = 1; i_ext_read = 1;
        i_core_addr = 32'h500; i_ext_addr = 32'h600;
        for (int k = 0; k < 20; k++) begin
            tick();
            i_mem_rd_data = $urandom;
            #1;
            checks++;
            if (((rr_core_gnt ^ rr_ext_gnt) !== 1'b1) || (k > 0 && rr_ext_gnt === prev_ext)) begin
                errors++;
                $display("FAIL rr_alternate k=%0d: got core/ext=%b%b prev_ext=%b", k, rr_core_gnt,
                         rr_ext_gnt, prev_ext);
            end
            checks++;
            if (rr_ext_rvalid !== prev_ext) begin
                errors++;
                $display("FAIL rr_rvalid k=%0d: got %b expected %b", k, rr_ext_rvalid, prev_ext);
            end
            checks++;
            if (obs_rr !== exp_vec(own_rr, stall_rr, rv_rr)) begin
                errors++;
                $display("FAIL rr_vec k=%0d: got %h expected %h", k, obs_rr, exp_vec(own_rr, stall_rr, rv_rr));
            end
            prev_ext = rr_ext_gnt;
        end
        drive_idle();
        #1;
        tick();
    endtask

    task automatic test_idle();
        drive_idle();
        #1;
        tick();
        for (int k = 0; k < 10; k++) begin
            i_core_read = 1'($urandom_range(1)); i_ext_write = 1'($urandom_range(1));
            i_ext_read = 1'($urandom_range(1)); i_core_addr = $urandom;
            #1;
            checks++;
            if ({fp_mem_read, fp_mem_write, fp_core_gnt, fp_ext_gnt,
                 rr_mem_read, rr_mem_write, rr_core_gnt, rr_ext_gnt} !== 8'b0) begin
                errors++;
                $display("FAIL idle k=%0d: got %b expected 00000000", k,
                         {fp_mem_read, fp_mem_write, fp_core_gnt, fp_ext_gnt,
                          rr_mem_read, rr_mem_write, rr_core_gnt, rr_ext_gnt});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_access();
        drive_idle();
        i_ext_req = 1;
        #1;
        tick();
        i_ext_req = 0; i_ext_read = 1; i_ext_addr = 32'h700;
        #1;
        checks++;
        if ({fp_ext_gnt, fp_mem_read} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: got %b expected 11", {fp_ext_gnt, fp_mem_read});
        end
        #2;
        i_rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({fp_core_gnt, fp_ext_gnt, fp_core_stall, fp_ext_rvalid, fp_mem_read, fp_mem_write, fp_mem_size,
             fp_mem_addr, fp_mem_wr_data} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0",
                     {fp_core_gnt, fp_ext_gnt, fp_core_stall, fp_ext_rvalid, fp_mem_read, fp_mem_write,
                      fp_mem_size, fp_mem_addr, fp_mem_wr_data});
        end
        tick();
        drive_idle();
        i_rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checks++;
            if ({fp_ext_rvalid, rr_ext_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_rvalid k=%0d: got %b expected 00", k, {fp_ext_rvalid, rr_ext_rvalid});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_core_req = ($urandom_range(3) != 0);
            i_ext_req  = ($urandom_range(3) != 0);
            i_core_read = 1'($urandom_range(1)); i_core_write = 1'($urandom_range(1));
            i_ext_read  = 1'($urandom_range(1)); i_ext_write  = 1'($urandom_range(1));
            i_core_size = 4'($urandom); i_ext_size = 4'($urandom);
            i_core_addr = $urandom; i_core_wr_data = $urandom;
            i_ext_addr  = $urandom; i_ext_wr_data  = $urandom;
            i_mem_rd_data = $urandom;
            #1;
            checks++;
            if (obs_fp !== exp_vec(own_fp, stall_fp, rv_fp)) begin
                errors++;
                $display("FAIL rand_fp c=%0d: got %h expected %h", c, obs_fp, exp_vec(own_fp, stall_fp, rv_fp));
            end
            checks++;
            if (obs_rr !== exp_vec(own_rr, stall_rr, rv_rr)) begin
                errors++;
                $display("FAIL rand_rr c=%0d: got %h expected %h", c, obs_rr, exp_vec(own_rr, stall_rr, rv_rr));
            end
            tick();
        end
    endtask

    initial begin
        i_rst_n = 0;
        drive_idle();
        model_reset();
        @(negedge i_clk);
        test_reset();
        test_core_only();
        test_ext_only();
        test_contention_fixed();
        test_contention_rr();
        test_idle();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between two masters: the pipeline's data interface (core) and an external master (boot loader / DMA / debug). Arbitrates on a one-cycle request-ahead handshake: request in cycle N, grant and command phase in N+1, read data in N+2. This timing matches the pipeline, where the request is raised in ID, the access is issued in EX and the data is consumed in WB. Provides fixed-priority or round-robin policy, an anti-starvation counter, and a stall indication for the core.

Parameters:
XLEN, 32, address/data width
ARB_MODE, 0, 0 = core fixed priority, 1 = round-robin
MAX_WAIT, 8, consecutive lost cycles before ext is force-granted (fixed-priority mode only); legal range 1..255

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_core_req  in  1  core request for next cycle
o_core_gnt  out  1  core owns memory this cycle
o_core_stall  out  1  core requested last cycle but was not granted
i_core_addr  in  XLEN  core address
i_core_wr_data  in  XLEN  core write data (lane-aligned)
i_core_size  in  4  core byte enables
i_core_read  in  1  core read strobe
i_core_write  in  1  core write strobe
o_core_rd_data  out  XLEN  read data to core
i_ext_req  in  1  ext request for next cycle
o_ext_gnt  out  1  ext owns memory this cycle
i_ext_addr  in  XLEN  ext address
i_ext_wr_data  in  XLEN  ext write data
i_ext_size  in  4  ext byte enables
i_ext_read  in  1  ext read strobe
i_ext_write  in  1  ext write strobe
o_ext_rd_data  out  XLEN  read data to ext
o_ext_rvalid  out  1  o_ext_rd_data valid
o_mem_addr  out  XLEN  memory address
o_mem_wr_data  out  XLEN  memory write data
o_mem_size  out  4  memory byte enables
o_mem_read  out  1  memory read strobe
o_mem_write  out  1  memory write strobe
i_mem_rd_data  in  XLEN  memory read data, 1-cycle latency

Behaviour:
- Reset: all registered state cleared. o_core_gnt=0, o_ext_gnt=0, o_core_stall=0, o_ext_rvalid=0, wait counter=0, round-robin pointer=CORE, data-phase owner=NONE. Reset is asynchronous and may be asserted mid-access: the in-flight access is dropped and no rvalid follows.
- Grant state (registered owner): IDLE, CORE, EXT. Next owner is computed from the requests of cycle N and loaded at the clock edge. At most one grant is ever active.
- Arbitration, ARB_MODE=0: core wins if i_core_req, unless wait_cnt==MAX_WAIT and i_ext_req, in which case ext wins. wait_cnt increments, saturating at MAX_WAIT, on each cycle ext requests and loses. It clears whenever ext is granted or ext is not requesting.
- Arbitration, ARB_MODE=1: when both masters request, the master not granted most recently wins. The pointer updates only on a grant.
- Single requester: that requester is always granted. No request: owner=IDLE.
- Command phase: while owner=X, o_mem_* = X's inputs; the other master's strobes are ignored. IDLE: o_mem_read=o_mem_write=0, addr/data/size=0.
- A granted master presenting neither strobe performs no access, and its slot is not reusable.
- o_core_stall = registered (core requested in N and was not granted).
- Data phase: a registered rd_owner records which master issued o_mem_read in the previous cycle.
- o_core_rd_data = i_mem_rd_data unconditionally, because the core's write-back path samples it without a valid.
- o_ext_rd_data = i_mem_rd_data. o_ext_rvalid = 1 exactly one cycle after an ext read command, and never for writes.
- Back-to-back grants to alternating masters are allowed with no bubble. The data phase of access N overlaps the command phase of access N+1.

Decomposition:
- Shared package: owner enum {OWN_IDLE, OWN_CORE, OWN_EXT} and a mem_cmd_t struct (addr, wr_data, size, read, write).
- One natural sub-module: arb_policy, the combinational next-owner logic plus the wait counter and round-robin pointer.
- Muxing and data-phase tracking stay in dmem_arbiter.

Test Plan:
- Core only: i_core_req=1 in cycle 5 with read of addr 0x100 in cycle 6 → o_core_gnt=1 and o_mem_read=1, addr 0x100 in cycle 6; mem data 0xDEADBEEF appears on o_core_rd_data in cycle 7; o_ext_rvalid stays 0.
- Ext only: ext write 0x55AA to 0x200 with size 4'b0011 → o_ext_gnt and o_mem_write=1 one cycle after request; no rvalid. Ext read follows → o_ext_rvalid=1 exactly one cycle after its command.
- Contention, ARB_MODE=0, MAX_WAIT=8: both request continuously → core granted 8 cycles, ext granted on the 9th; o_core_stall=1 in the cycle after the lost request; pattern repeats.
- Contention, ARB_MODE=1: both request continuously → grants alternate CORE, EXT, CORE… with no idle cycle, and rvalid only on EXT read slots.
- Reset mid-access: ext read granted, i_rst_n dropped before the data cycle → all outputs return to 0 immediately; no o_ext_rvalid after reset is released.
- Idle: no requests → o_mem_read=o_mem_write=0 and both grants 0 for all cycles.
